// File: rtl/reg_writeback_ctrl_if.sv
// Producer handshakes, register-file write port and forwarding lookup for reg_writeback_ctrl.
// The master modport is the controller side; the slave modport is its environment.
interface reg_writeback_ctrl_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_alu_valid;
  logic [ADDR_W-1:0] in_alu_add;
  logic [DATA_W-1:0] in_alu_val;
  logic              out_alu_ready;
  logic              in_mem_valid;
  logic [ADDR_W-1:0] in_mem_add;
  logic [DATA_W-1:0] in_mem_val;
  logic              out_mem_ready;
  logic              in_hold;
  logic              out_write_en;
  logic [ADDR_W-1:0] out_write_reg_add;
  logic [DATA_W-1:0] out_write_reg_val;
  logic [ADDR_W-1:0] in_fwd_add;
  logic              out_fwd_hit;
  logic [DATA_W-1:0] out_fwd_val;
  logic [CNT_W-1:0]  out_count;

  modport master (
    input  in_alu_valid, in_alu_add, in_alu_val,
    input  in_mem_valid, in_mem_add, in_mem_val,
    input  in_hold, in_fwd_add,
    output out_alu_ready, out_mem_ready,
    output out_write_en, out_write_reg_add, out_write_reg_val,
    output out_fwd_hit, out_fwd_val, out_count
  );

  modport slave (
    output in_alu_valid, in_alu_add, in_alu_val,
    output in_mem_valid, in_mem_add, in_mem_val,
    output in_hold, in_fwd_add,
    input  out_alu_ready, out_mem_ready,
    input  out_write_en, out_write_reg_add, out_write_reg_val,
    input  out_fwd_hit, out_fwd_val, out_count
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back controller: arbitrates ALU/load results into an in-order FIFO,
// drains one write per cycle and forwards the youngest pending value for a lookup address.
module reg_writeback_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input logic                 in_clk,
  input logic                 in_rst,
  reg_writeback_ctrl_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifo_add_q [DEPTH];
  logic [DATA_W-1:0] fifo_val_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              we_q;
  logic [ADDR_W-1:0] wadd_q;
  logic [DATA_W-1:0] wval_q;

  logic              not_full, alu_ready, mem_fire, alu_fire, push, pop;
  logic [ADDR_W-1:0] push_add;
  logic [DATA_W-1:0] push_val;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_val;
  logic [PTR_W-1:0]  idx;

  // Readiness looks only at the registered count, so a full FIFO refuses even when popping.
  always_comb begin
    not_full  = (count_q != FULL) && !in_rst;
    alu_ready = not_full && !bus.in_mem_valid;
    mem_fire  = bus.in_mem_valid && not_full;
    alu_fire  = bus.in_alu_valid && alu_ready;
    push      = mem_fire || alu_fire;
    push_add  = mem_fire ? bus.in_mem_add : bus.in_alu_add;
    push_val  = mem_fire ? bus.in_mem_val : bus.in_alu_val;
    pop       = (count_q != '0) && !bus.in_hold;
  end

  always_ff @(posedge in_clk) begin
    if (push) begin
      fifo_add_q[wr_ptr_q] <= push_add;
      fifo_val_q[wr_ptr_q] <= push_val;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wadd_q   <= '0;
      wval_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        we_q     <= 1'b1;
        wadd_q   <= fifo_add_q[rd_ptr_q];
        wval_q   <= fifo_val_q[rd_ptr_q];
      end else begin
        we_q     <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan oldest to youngest so later matches override; the output stage is older than any entry.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    idx     = '0;
    if (we_q && (wadd_q == bus.in_fwd_add)) begin
      fwd_hit = 1'b1;
      fwd_val = wval_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fifo_add_q[idx] == bus.in_fwd_add)) begin
        fwd_hit = 1'b1;
        fwd_val = fifo_val_q[idx];
      end
    end
  end

  assign bus.out_mem_ready     = not_full;
  assign bus.out_alu_ready     = alu_ready;
  assign bus.out_write_en      = we_q;
  assign bus.out_write_reg_add = wadd_q;
  assign bus.out_write_reg_val = wval_q;
  assign bus.out_fwd_hit       = fwd_hit;
  assign bus.out_fwd_val       = fwd_val;
  assign bus.out_count         = count_q;
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed vector table, queue-based reference
// model for hold/full, wrap-around, random traffic and asynchronous reset mid-drain.
module tb_reg_writeback_ctrl;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  always #5 in_clk = ~in_clk;

  reg_writeback_ctrl_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_writeback_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus.master)
  );

  typedef struct packed {
    logic [7:0]  add;
    logic [15:0] val;
  } ent_t;

  typedef struct {
    logic        av;
    logic [7:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [7:0]  ma;
    logic [15:0] md;
    logic        hold;
    logic [7:0]  fa;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [7:0]  e_wa;
    logic [15:0] e_wv;
    int          e_cnt;
    logic        e_hit;
    logic [15:0] e_fv;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending entries oldest-first plus the registered write stage.
  ent_t        mq[$];
  logic        m_we;
  logic [7:0]  m_wadd;
  logic [15:0] m_wval;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ar, input logic mr, input logic we,
                            input logic [7:0] wa, input logic [15:0] wv, input int cnt,
                            input logic hit, input logic [15:0] fv);
    check({tag, " alu_ready"}, 32'(bus.out_alu_ready), 32'(ar));
    check({tag, " mem_ready"}, 32'(bus.out_mem_ready), 32'(mr));
    check({tag, " write_en"}, 32'(bus.out_write_en), 32'(we));
    check({tag, " write_add"}, 32'(bus.out_write_reg_add), 32'(wa));
    check({tag, " write_val"}, 32'(bus.out_write_reg_val), 32'(wv));
    check({tag, " count"}, 32'(bus.out_count), cnt);
    check({tag, " fwd_hit"}, 32'(bus.out_fwd_hit), 32'(hit));
    check({tag, " fwd_val"}, 32'(bus.out_fwd_val), 32'(fv));
  endtask

  task automatic drive(input logic av, input logic [7:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [7:0] ma, input logic [15:0] md,
                       input logic hold, input logic [7:0] fa);
    bus.in_alu_valid = av;
    bus.in_alu_add   = aa;
    bus.in_alu_val   = ad;
    bus.in_mem_valid = mv;
    bus.in_mem_add   = ma;
    bus.in_mem_val   = md;
    bus.in_hold      = hold;
    bus.in_fwd_add   = fa;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic step(input string tag, input logic av, input logic [7:0] aa,
                      input logic [15:0] ad, input logic mv, input logic [7:0] ma,
                      input logic [15:0] md, input logic hold, input logic [7:0] fa);
    logic        e_mr, e_ar, e_hit, do_pop, do_push;
    logic [15:0] e_fv;
    ent_t        nxt;
    @(negedge in_clk);
    drive(av, aa, ad, mv, ma, md, hold, fa);
    #1;
    e_mr  = (mq.size() != DEPTH);
    e_ar  = e_mr && !mv;
    e_hit = 1'b0;
    e_fv  = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].add == fa) begin
        e_hit = 1'b1;
        e_fv  = mq[i].val;
        break;
      end
    end
    if (!e_hit && m_we && (m_wadd == fa)) begin
      e_hit = 1'b1;
      e_fv  = m_wval;
    end
    check_outs(tag, e_ar, e_mr, m_we, m_wadd, m_wval, mq.size(), e_hit, e_fv);
    do_pop  = (mq.size() != 0) && !hold;
    do_push = 1'b0;
    nxt     = '0;
    if (mv && e_mr) begin
      do_push = 1'b1;
      nxt     = {ma, md};
    end else if (av && e_ar) begin
      do_push = 1'b1;
      nxt     = {aa, ad};
    end
    @(posedge in_clk);
    if (do_pop) begin
      m_we   = 1'b1;
      m_wadd = mq[0].add;
      m_wval = mq[0].val;
      void'(mq.pop_front());
    end else begin
      m_we = 1'b0;
    end
    if (do_push) mq.push_back(nxt);
  endtask

  task automatic idle(input string tag, input int n, input logic [7:0] fa);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, fa);
  endtask

  initial begin
    //                av    aa     ad        mv    ma     md        hold  fa
    //                ar    mr    we    wa     wv        cnt hit   fv
    vecs[0]  = '{1'b1, 8'h05, 16'h1234, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h05,
                 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h05,
                 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1, 1'b1, 16'h1234};
    vecs[2]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h05,
                 1'b1, 1'b1, 1'b1, 8'h05, 16'h1234, 0, 1'b1, 16'h1234};
    vecs[3]  = '{1'b1, 8'h01, 16'hAAAA, 1'b1, 8'h02, 16'hBBBB, 1'b0, 8'h01,
                 1'b0, 1'b1, 1'b0, 8'h05, 16'h1234, 0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 8'h01, 16'hAAAA, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h02,
                 1'b1, 1'b1, 1'b0, 8'h05, 16'h1234, 1, 1'b1, 16'hBBBB};
    vecs[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h01,
                 1'b1, 1'b1, 1'b1, 8'h02, 16'hBBBB, 1, 1'b1, 16'hAAAA};
    vecs[6]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h02,
                 1'b1, 1'b1, 1'b1, 8'h01, 16'hAAAA, 0, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h01,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 8'h07, 16'h0001, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 0, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 8'h07, 16'h0002, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 1, 1'b1, 16'h0001};
    vecs[10] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h07,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 2, 1'b1, 16'h0002};
    vecs[11] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h08,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 2, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h07,
                 1'b1, 1'b1, 1'b0, 8'h01, 16'hAAAA, 2, 1'b1, 16'h0002};
    vecs[13] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h07,
                 1'b1, 1'b1, 1'b1, 8'h07, 16'h0001, 1, 1'b1, 16'h0002};
    vecs[14] = '{1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h07,
                 1'b1, 1'b1, 1'b1, 8'h07, 16'h0002, 0, 1'b1, 16'h0002};

    drive(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
    repeat (2) @(negedge in_clk);
    #1;
    check_outs("in_reset", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 16'h0000);
    @(negedge in_clk);
    in_rst = 1'b0;

    // Directed table: single push latency, arbitration priority, duplicate-address forwarding.
    for (int i = 0; i < 15; i++) begin
      @(negedge in_clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
            vecs[i].hold, vecs[i].fa);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_ar, vecs[i].e_mr, vecs[i].e_we,
                 vecs[i].e_wa, vecs[i].e_wv, vecs[i].e_cnt, vecs[i].e_hit, vecs[i].e_fv);
      @(posedge in_clk);
    end

    mq.delete();
    m_we   = 1'b0;
    m_wadd = 8'h07;
    m_wval = 16'h0002;

    // Fill under hold, one extra attempt while full, then drain.
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, 8'(8'h30 + i), 16'(16'hC000 + i), 1'b0, 8'h00, 16'h0000, 1'b1, 8'h31);
    idle("drain", 6, 8'h32);

    // Alternating sources with hold toggling; repeated addresses exercise youngest-first across wrap.
    for (int i = 0; i < 10; i++)
      step("wrap", 1'b1, 8'(8'h20 + i % 3), 16'(16'h0100 + i), i[0], 8'(8'h20 + (i + 1) % 3),
           16'(16'h0200 + i), i[1], 8'(8'h20 + i % 3));
    idle("wrap_drain", 6, 8'h21);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 5)), 16'($urandom),
           1'($urandom_range(0, 9) < 3), 8'($urandom_range(0, 5)));
    idle("rand_drain", 6, 8'h00);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1'b1, 8'(8'h40 + i), 16'(16'hD000 + i), 1'b0, 8'h00, 16'h0000, 1'b1, 8'h40);
    step("pre_rst", 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h40);
    @(negedge in_clk);
    #2;
    in_rst = 1'b1;
    #1;
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 1'b0, 16'h0000);
    mq.delete();
    m_we   = 1'b0;
    m_wadd = 8'h00;
    m_wval = 16'h0000;
    @(negedge in_clk);
    in_rst = 1'b0;
    idle("post_rst", 4, 8'h40);
    step("post_rst", 1'b1, 8'h55, 16'h5555, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h55);
    idle("post_rst", 3, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Initiator side of the register-file write port. Collects results from two producers, the ALU and the memory-load path, through valid/ready handshakes.
- Buffers results in a small in-order FIFO and drains them one per cycle onto the register-file write interface (write enable, address, value).
- Provides a forwarding lookup so operand fetch can see writes that have not yet committed.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2
- ADDR_W, 8, register address width
- DATA_W, 16, register data width

Ports:
- in_clk  input  1  clock; all state updates on rising edge
- in_rst  input  1  asynchronous, active-high reset
- in_alu_valid  input  1  ALU result valid
- in_alu_add  input  ADDR_W  ALU destination register
- in_alu_val  input  DATA_W  ALU result
- out_alu_ready  output  1  ALU result accepted this cycle when valid and ready
- in_mem_valid  input  1  load result valid
- in_mem_add  input  ADDR_W  load destination register
- in_mem_val  input  DATA_W  load data
- out_mem_ready  output  1  load result accepted this cycle when valid and ready
- in_hold  input  1  stall drain; no FIFO pop while high
- out_write_en  output  1  register-file write enable (registered)
- out_write_reg_add  output  ADDR_W  write address (registered)
- out_write_reg_val  output  DATA_W  write data (registered)
- in_fwd_add  input  ADDR_W  forwarding lookup address
- out_fwd_hit  output  1  pending write to in_fwd_add exists
- out_fwd_val  output  DATA_W  youngest pending value for in_fwd_add
- out_count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (in_rst high, asynchronous):
  - FIFO emptied: read pointer, write pointer and count = 0.
  - out_write_en = 0, out_write_reg_add = 0, out_write_reg_val = 0.
  - In-flight entries are discarded, with no partial write.
  - While in reset, out_alu_ready = out_mem_ready = 0.
- Ready, combinational:
  - out_mem_ready = (count != DEPTH).
  - out_alu_ready = (count != DEPTH) && !in_mem_valid.
  - Memory has fixed priority. At most one push per cycle.
  - Full-state readiness uses count only: no push while full, even when a pop occurs in the same cycle.
- Push at an edge where the selected source has valid && ready: entry {add, val} written at the write pointer; write pointer increments modulo DEPTH.
- Pop/drain at each edge:
  - If count != 0 and !in_hold: head loaded into out_write_reg_add/out_write_reg_val, out_write_en <= 1, read pointer increments modulo DEPTH.
  - Otherwise out_write_en <= 0, and add/val hold their previous values.
- Count:
  - push-only +1; pop-only -1; simultaneous push and pop unchanged; bounded 0..DEPTH.
  - Push into an empty FIFO and pop from it never happen in the same edge, because pop uses the pre-edge count.
- Latency:
  - Entry accepted at edge k into an empty FIFO with in_hold low: out_write_en high in cycle k+1. The register file commits at edge k+2.
  - Throughput: one write per cycle.
- Ordering: strict acceptance order. Duplicate destination addresses are all emitted, in order, so the last write wins in the register file.
- Forwarding, combinational:
  - Search space: valid FIFO entries plus the output stage, counted only when out_write_en = 1.
  - Hit if any address equals in_fwd_add.
  - out_fwd_val is taken from the youngest matching entry; the FIFO tail is youngest and the output stage is oldest.
  - On no hit, out_fwd_val = 0.
- Wrap-around: pointers wrap modulo DEPTH. The youngest-first search must be correct across the wrap.
- in_hold asserted mid-drain: out_write_en deasserts at the next edge and the FIFO contents are preserved. Drain resumes at the first edge after in_hold drops.

Test Plan:
1. Reset, then ALU push {add=0x05, val=0x1234} at edge 1 -> out_write_en=1, add=0x05, val=0x1234 in cycle 2; out_count returns to 0; out_write_en=0 in cycle 3.
2. Both valid in the same cycle, ALU {0x01, 0xAAAA} and MEM {0x02, 0xBBBB} -> out_alu_ready=0 and MEM accepted first. ALU held valid is accepted next cycle. Writes emerge in order 0x02 then 0x01 on consecutive cycles.
3. in_hold=1, push 4 entries -> out_count=4, both readies 0, further valid ignored. Release in_hold -> 4 consecutive cycles of out_write_en=1 in acceptance order; then readies return to 1.
4. Forwarding: hold, push {0x07, 0x0001} then {0x07, 0x0002}, set in_fwd_add=0x07 -> out_fwd_hit=1, out_fwd_val=0x0002. With in_fwd_add=0x08 -> hit=0, val=0.
5. Wrap-around: stream 10 alternating pushes with in_hold toggling -> every value appears exactly once, in order. Forwarding stays correct when the tail pointer wraps to 0.
6. Assert in_rst mid-drain with 3 entries queued -> out_write_en=0 and out_count=0 immediately (asynchronous). No write appears after reset release until a new push.
